imem_responder: RTL and testbench
=================================

# imem_responder

Responder side of the instruction fetch interface. Accepts fetch requests from the fetch stage over a valid/ready channel and reads a word-addressed instruction array. It returns responses in order, with a fixed pipeline latency, over a second valid/ready channel, and buffers them so the fetch stage can apply backpressure. A loader write port fills the array, and a flush input discards in-flight fetches when a branch redirects the program counter.

## Interface
- ADDR_WIDTH, 32, byte address width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 256, array size in words (power of two)
- BASE_ADDR, 0, byte address of word 0 (word-aligned)
- LATENCY, 2, cycles from request acceptance to response visibility (1..4)
- RSP_DEPTH, 4, response buffer entries (must be >= LATENCY)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_WIDTH  fetch byte address (the fetch PC)
- rsp_valid  out  1  response present
- rsp_ready  in  1  fetch stage takes the response
- rsp_instr  out  INSTR_WIDTH  instruction word
- rsp_addr  out  ADDR_WIDTH  address of the request that produced this response
- rsp_err  out  2  00 ok, 01 misaligned, 10 out of range
- flush  in  1  discard all in-flight and buffered responses
- ld_en  in  1  loader write strobe
- ld_addr  in  $clog2(DEPTH)  loader word index
- ld_data  in  INSTR_WIDTH  loader write data

## Operation
- **Accept.** A request is accepted on an edge where req_valid && req_ready.
- **req_ready.** Equals !reset && !flush && (inflight + buffered) < RSP_DEPTH.
  - inflight: accepted requests not yet in the buffer.
  - buffered: entries in the response buffer.
  - This credit rule guarantees the buffer never overflows.
- **Index.** idx = (req_addr - BASE_ADDR) >> 2, in ADDR_WIDTH-bit arithmetic. The subtraction wraps, so an address below BASE_ADDR produces a huge idx and is out of range.
- **Error priority.**
  - req_addr[1:0] != 0: rsp_err=01 (takes priority).
  - Otherwise idx >= DEPTH: rsp_err=10.
  - On any error, rsp_instr = 32'h0000_0013 (NOP) and the array is not used.
- **Read.** The array is read at the acceptance edge and is read-first. An ld_en write to the same index on that edge does not affect the returned word; the new data is visible to requests accepted on later edges.
- **Pipeline.** Requests travel through LATENCY stages (valid bit, addr, instr, err per stage) and the final stage pushes into the response FIFO.
- **Response output.** rsp_valid = FIFO not empty, with head fields on rsp_*. An entry pops on rsp_valid && rsp_ready.
  - rsp_* must hold steady while rsp_valid && !rsp_ready.
  - Responses leave in strict acceptance order.
- **Flush.** When flush is high at an edge:
  - Clear all pipeline valid bits and empty the FIFO.
  - No request is accepted on that edge, because req_ready is low.
  - A pop requested on the same edge is ignored.
  - ld_en writes still occur.
  - rsp_valid is 0 in the following cycle.
- **Reset.** The edge with reset high clears the pipeline, FIFO pointers and count. Array contents are not reset. Reset mid-operation drops everything, exactly like flush.
- **Loader.** ld_en writes ld_data into array[ld_addr] at the edge, independent of the handshakes.

## Timing
- **Reset values:** req_ready=0 (while reset is high), rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=00.
- **After reset:** req_ready=1 in the first cycle after reset deasserts, unless flush is high.
- **Latency:** a request accepted at edge E0 gives rsp_valid=1 in the cycle after edge E0+LATENCY-1. This is exactly LATENCY cycles after the acceptance cycle when rsp_ready is held high.
- **Throughput:** with rsp_ready=1 continuously, one request is accepted and one response delivered every cycle, with no bubbles.
- **Credit release:** a pop frees its credit in the same cycle, combinationally. With the FIFO full and rsp_ready=1, req_ready=1.
- **Simultaneous push and pop on a full FIFO:** legal. Count is unchanged.

## Test plan
- **Sequential fetch, LATENCY=2.**
  - Stimulus: load words 0..7 with 0xA0+i; request addresses 0x0, 0x4, ... 0x1C back-to-back with rsp_ready=1.
  - Response: eight in-order responses, the first in the 2nd cycle after acceptance, instr=0xA0..0xA7, rsp_err=00, no gaps.
- **Backpressure.**
  - Stimulus: hold rsp_ready=0 and request continuously.
  - Response: exactly RSP_DEPTH=4 accepts, then req_ready=0. rsp_* stays stable. Releasing rsp_ready drains 4 ordered responses and re-opens req_ready immediately.
- **Errors.**
  - Stimulus: request 0x6, then 0x400 (DEPTH=256), then 0x401.
  - Response: err=01, 10, 01 in order, instr=0x00000013 each.
- **Flush mid-stream.**
  - Stimulus: 3 requests in flight or buffered, assert flush one cycle with req_valid=1.
  - Response: that request is not accepted. rsp_valid=0 the next cycle. The next accepted request returns first, with correct data.
- **Read-first collision.**
  - Stimulus: array[5]=0x11; on the same edge, accept a request for 0x14 and apply ld_en to index 5 with 0x22.
  - Response: that request returns 0x11. A following request for 0x14 returns 0x22.
- **Reset mid-operation.**
  - Stimulus: reset for one cycle with the FIFO full.
  - Response: rsp_valid=0 and req_ready=0 during reset, req_ready=1 after. Array data is retained (re-fetching word 0 returns 0xA0).

Source files
------------

// File: rtl/imem_responder.sv
`default_nettype none
// imem_responder: instruction memory responder with fixed read latency and a credit-managed response FIFO.
// Revision: 1.0

module imem_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    LATENCY     = 2,
  parameter int                    RSP_DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [INSTR_WIDTH-1:0]   rsp_instr,
  output logic [ADDR_WIDTH-1:0]    rsp_addr,
  output logic [1:0]               rsp_err,
  input  logic                     flush,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [INSTR_WIDTH-1:0]   ld_data
);

  localparam int IW   = $clog2(DEPTH);
  localparam int NSTG = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW   = $clog2(RSP_DEPTH + 1);
  localparam int OW   = CW + 1;
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic                   drop;
  logic                   accept;
  logic                   pop;
  logic [ADDR_WIDTH-1:0]  word_off;
  logic [1:0]             in_err;
  logic [INSTR_WIDTH-1:0] in_instr;
  logic [CW-1:0]          inflight;
  logic [OW-1:0]          occupancy;

  logic                   push_v;
  logic [ADDR_WIDTH-1:0]  push_addr;
  logic [INSTR_WIDTH-1:0] push_instr;
  logic [1:0]             push_err;

  logic [INSTR_WIDTH-1:0] fifo_instr [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_addr  [RSP_DEPTH];
  logic [1:0]             fifo_err   [RSP_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          count;

  assign drop   = reset || flush;
  assign accept = req_valid && req_ready;
  assign pop    = rsp_valid && rsp_ready && !flush;

  // Asynchronous array read before the edge gives read-first behaviour against ld_en.
  always_comb begin
    word_off = (req_addr - BASE_ADDR) >> 2;
    in_err   = 2'b00;
    if (req_addr[1:0] != 2'b00) begin
      in_err = 2'b01;
    end else if (word_off >= ADDR_WIDTH'(DEPTH)) begin
      in_err = 2'b10;
    end
    in_instr = (in_err != 2'b00) ? NOP : mem[word_off[IW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // LATENCY-1 register stages; the FIFO write is the final stage.
  generate
    if (LATENCY > 1) begin : g_pipe
      logic [NSTG-1:0]        pipe_v;
      logic [ADDR_WIDTH-1:0]  pipe_addr  [NSTG];
      logic [INSTR_WIDTH-1:0] pipe_instr [NSTG];
      logic [1:0]             pipe_err   [NSTG];

      always_ff @(posedge clk) begin
        if (drop) begin
          pipe_v <= '0;
        end else begin
          pipe_v[0] <= accept;
          for (int i = 1; i < NSTG; i++) begin
            pipe_v[i] <= pipe_v[i-1];
          end
        end
        pipe_addr[0]  <= req_addr;
        pipe_instr[0] <= in_instr;
        pipe_err[0]   <= in_err;
        for (int i = 1; i < NSTG; i++) begin
          pipe_addr[i]  <= pipe_addr[i-1];
          pipe_instr[i] <= pipe_instr[i-1];
          pipe_err[i]   <= pipe_err[i-1];
        end
      end

      always_comb begin
        inflight = '0;
        for (int i = 0; i < NSTG; i++) begin
          inflight = inflight + CW'(pipe_v[i]);
        end
      end

      assign push_v     = pipe_v[NSTG-1];
      assign push_addr  = pipe_addr[NSTG-1];
      assign push_instr = pipe_instr[NSTG-1];
      assign push_err   = pipe_err[NSTG-1];
    end else begin : g_nopipe
      assign inflight   = '0;
      assign push_v     = accept;
      assign push_addr  = req_addr;
      assign push_instr = in_instr;
      assign push_err   = in_err;
    end
  endgenerate

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (drop) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_v) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_v, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_v && !drop) begin
      fifo_instr[wr_ptr] <= push_instr;
      fifo_addr[wr_ptr]  <= push_addr;
      fifo_err[wr_ptr]   <= push_err;
    end
  end

  assign rsp_valid = !reset && (count != '0);
  assign rsp_instr = rsp_valid ? fifo_instr[rd_ptr] : '0;
  assign rsp_addr  = rsp_valid ? fifo_addr[rd_ptr]  : '0;
  assign rsp_err   = rsp_valid ? fifo_err[rd_ptr]   : 2'b00;

  // A pop this cycle returns its credit immediately, so a full FIFO being drained still accepts.
  assign occupancy = OW'(inflight) + OW'(count) - OW'(rsp_valid && rsp_ready);
  assign req_ready = !reset && !flush && (occupancy < OW'(RSP_DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// tb_imem_responder: randomized and directed checks of imem_responder against a queue-based reference model.
// Revision: 1.0

module tb_imem_responder;

  localparam int          AW        = 32;
  localparam int          XW        = 32;
  localparam int          DEPTH     = 256;
  localparam logic [31:0] BASE_ADDR = 32'h0;
  localparam int          LATENCY   = 2;
  localparam int          RSP_DEPTH = 4;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [XW-1:0] rsp_instr;
  logic [AW-1:0] rsp_addr;
  logic [1:0]    rsp_err;
  logic          flush;
  logic          ld_en;
  logic [7:0]    ld_addr;
  logic [XW-1:0] ld_data;

  imem_responder #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(XW),
    .DEPTH      (DEPTH),
    .BASE_ADDR  (BASE_ADDR),
    .LATENCY    (LATENCY),
    .RSP_DEPTH  (RSP_DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_addr (rsp_addr),
    .rsp_err  (rsp_err),
    .flush    (flush),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  err;
    int          vis;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mmem [DEPTH];
  int          cyc;
  int          n_cmp;
  int          n_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic rsp_t model_fetch(input logic [31:0] a);
    rsp_t        r;
    logic [31:0] word;
    word    = (a - BASE_ADDR) / 4;
    r.addr  = a;
    r.vis   = 0;
    if (a % 4 != 0) begin
      r.err   = 2'b01;
      r.instr = NOP;
    end else if (word >= DEPTH) begin
      r.err   = 2'b10;
      r.instr = NOP;
    end else begin
      r.err   = 2'b00;
      r.instr = mmem[word];
    end
    return r;
  endfunction

  // One clock cycle: compare outputs for the current inputs, then advance the model at the edge.
  task automatic cycle();
    bit   ev;
    bit   pop;
    bit   exp_rdy;
    bit   acc;
    int   occ;
    rsp_t e;
    #1;
    ev      = !reset && q.size() > 0 && q[0].vis <= cyc;
    pop     = ev && rsp_ready;
    occ     = q.size() - (pop ? 1 : 0);
    exp_rdy = !reset && !flush && occ < RSP_DEPTH;
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    check_eq("rsp_valid", 64'(rsp_valid), 64'(ev));
    if (ev) begin
      check_eq("rsp_addr",  64'(rsp_addr),  64'(q[0].addr));
      check_eq("rsp_instr", 64'(rsp_instr), 64'(q[0].instr));
      check_eq("rsp_err",   64'(rsp_err),   64'(q[0].err));
    end else if (reset) begin
      check_eq("rst_instr", 64'(rsp_instr), 64'd0);
      check_eq("rst_addr",  64'(rsp_addr),  64'd0);
      check_eq("rst_err",   64'(rsp_err),   64'd0);
    end
    acc = req_valid && exp_rdy;
    if (acc) e = model_fetch(req_addr);
    @(posedge clk);
    if (reset || flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e.vis = cyc + LATENCY;
        q.push_back(e);
      end
    end
    if (ld_en) mmem[ld_addr] = ld_data;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input bit rr);
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    cycle();
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = 8'(idx);
    ld_data = d;
    cycle();
    ld_en   = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 6) return {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
    if (sel == 7) return {$urandom_range(0, 1023), 2'b01} | 32'h1;
    if (sel == 8) return 32'h400 + 4 * $urandom_range(0, 255);
    return $urandom;
  endfunction

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cyc       = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    flush     = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    cycle();
    cycle();
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) load(i, $urandom);
    for (int i = 0; i < 8; i++) load(i, 32'hA0 + i);

    // Sequential back-to-back fetch
    for (int i = 0; i < 8; i++) drive(1'b1, 32'(4 * i), 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1);

    // Backpressure then release
    for (int i = 0; i < 8; i++) drive(1'b1, 32'(4 * (8 + i)), 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 1'b1);

    // Error responses
    drive(1'b1, 32'h6, 1'b1);
    drive(1'b1, 32'h400, 1'b1);
    drive(1'b1, 32'h401, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1);

    // Flush mid-stream
    for (int i = 0; i < 3; i++) drive(1'b1, 32'(4 * i), 1'b0);
    flush = 1'b1;
    drive(1'b1, 32'hC, 1'b0);
    flush = 1'b0;
    drive(1'b1, 32'h10, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1);

    // Read-first collision on word 5
    load(5, 32'h11);
    ld_en   = 1'b1;
    ld_addr = 8'd5;
    ld_data = 32'h22;
    drive(1'b1, 32'h14, 1'b1);
    ld_en = 1'b0;
    drive(1'b1, 32'h14, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1);

    // Reset with the FIFO full, then refetch word 0
    for (int i = 0; i < 6; i++) drive(1'b1, 32'(4 * i), 1'b0);
    reset = 1'b1;
    drive(1'b1, 32'h8, 1'b1);
    reset = 1'b0;
    drive(1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      flush   = ($urandom_range(0, 31) == 0);
      reset   = ($urandom_range(0, 149) == 0);
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = 8'($urandom_range(0, DEPTH - 1));
      ld_data = $urandom;
      drive($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0);
    end
    flush = 1'b0;
    reset = 1'b0;
    ld_en = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
